// File: rtl/me_search_ctrl_if.sv
// rtl/me_search_ctrl_if.sv - candidate/result stream bundle between the ME controller and the SAD datapath
interface me_search_ctrl_if #(
  parameter int SAD_WIDTH = 16,
  parameter int MV_WIDTH  = 6
);
  logic                       cand_valid;
  logic                       cand_ready;
  logic signed [MV_WIDTH-1:0] cand_mvx;
  logic signed [MV_WIDTH-1:0] cand_mvy;
  logic                       sad_valid;
  logic [SAD_WIDTH-1:0]       sad_in;

  // controller side: issues candidates, consumes SAD results
  modport master (
    output cand_valid, cand_mvx, cand_mvy,
    input  cand_ready, sad_valid, sad_in
  );

  // datapath side: accepts candidates, returns SAD results in issue order
  modport slave (
    input  cand_valid, cand_mvx, cand_mvy,
    output cand_ready, sad_valid, sad_in
  );
endinterface

// File: rtl/me_search_ctrl.sv
// rtl/me_search_ctrl.sv - full-search motion-estimation controller; optional zero-vector bias under ME_ZERO_BIAS_EN
module me_search_ctrl #(
  parameter int SAD_WIDTH    = 16,
  parameter int SEARCH_RANGE = 4,
  parameter int MV_WIDTH     = 6,
  parameter int ZERO_BIAS    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  me_search_ctrl_if.master           bus,
  output logic                       busy,
  output logic                       done,
  output logic [SAD_WIDTH-1:0]       best_sad,
  output logic signed [MV_WIDTH-1:0] best_mvx,
  output logic signed [MV_WIDTH-1:0] best_mvy
);

  localparam int NCAND = (2 * SEARCH_RANGE + 1) * (2 * SEARCH_RANGE + 1);
  localparam int CW    = $clog2(NCAND + 1);
  localparam logic [CW-1:0]              LAST_CNT = CW'(NCAND);
  localparam logic signed [MV_WIDTH-1:0] MV_MAX   = MV_WIDTH'(SEARCH_RANGE);
  localparam logic signed [MV_WIDTH-1:0] MV_MIN   = -MV_MAX;
  localparam logic signed [MV_WIDTH-1:0] MV_ONE   = MV_WIDTH'(1);
  localparam logic [SAD_WIDTH-1:0]       BIAS     = SAD_WIDTH'(ZERO_BIAS);
`ifdef ME_ZERO_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                     state;
  logic signed [MV_WIDTH-1:0] ret_x;
  logic signed [MV_WIDTH-1:0] ret_y;
  logic [CW-1:0]              outstanding;
  logic [CW-1:0]              ret_cnt;

  logic                 hs;
  logic                 acc;
  logic                 issue_last;
  logic                 ret_final;
  logic [CW-1:0]        ret_cnt_nx;
  logic [SAD_WIDTH-1:0] sad_eff;

  // this cycle's handshake, result acceptance (a same-cycle issue counts as outstanding) and biased SAD
  always_comb begin
    hs         = (state == ISSUE) && bus.cand_valid && bus.cand_ready;
    acc        = bus.sad_valid && ((state == ISSUE) || (state == DRAIN)) &&
                 ((outstanding != '0) || hs);
    issue_last = hs && (bus.cand_mvx == MV_MAX) && (bus.cand_mvy == MV_MAX);
    ret_cnt_nx = ret_cnt + CW'(acc);
    ret_final  = acc && (ret_cnt_nx == LAST_CNT);
    sad_eff    = bus.sad_in;
    if (BIAS_EN && (ret_x == '0) && (ret_y == '0))
      sad_eff = (bus.sad_in > BIAS) ? (bus.sad_in - BIAS) : '0;
  end

  // search FSM with raster issue/return counters and minimum-SAD tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bus.cand_valid <= 1'b0;
      bus.cand_mvx   <= '0;
      bus.cand_mvy   <= '0;
      ret_x          <= '0;
      ret_y          <= '0;
      outstanding    <= '0;
      ret_cnt        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      best_sad       <= '0;
      best_mvx       <= '0;
      best_mvy       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state          <= ISSUE;
            busy           <= 1'b1;
            bus.cand_valid <= 1'b1;
            bus.cand_mvx   <= MV_MIN;
            bus.cand_mvy   <= MV_MIN;
            ret_x          <= MV_MIN;
            ret_y          <= MV_MIN;
            outstanding    <= '0;
            ret_cnt        <= '0;
            best_sad       <= '1;
            best_mvx       <= '0;
            best_mvy       <= '0;
          end
        end
        ISSUE, DRAIN: begin
          if (hs && !issue_last) begin
            if (bus.cand_mvx == MV_MAX) begin
              bus.cand_mvx <= MV_MIN;
              bus.cand_mvy <= bus.cand_mvy + MV_ONE;
            end else begin
              bus.cand_mvx <= bus.cand_mvx + MV_ONE;
            end
          end
          if (acc) begin
            if (ret_x == MV_MAX) begin
              ret_x <= MV_MIN;
              ret_y <= ret_y + MV_ONE;
            end else begin
              ret_x <= ret_x + MV_ONE;
            end
            if (sad_eff < best_sad) begin
              best_sad <= sad_eff;
              best_mvx <= ret_x;
              best_mvy <= ret_y;
            end
          end
          outstanding <= outstanding + CW'(hs) - CW'(acc);
          ret_cnt     <= ret_cnt_nx;
          if (abort) begin
            state          <= IDLE;
            busy           <= 1'b0;
            bus.cand_valid <= 1'b0;
          end else if (ret_final && ((state == DRAIN) || issue_last)) begin
            state          <= DONE;
            busy           <= 1'b0;
            bus.cand_valid <= 1'b0;
            done           <= 1'b1;
          end else if (issue_last) begin
            state          <= DRAIN;
            bus.cand_valid <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_search_ctrl.sv
// tb/tb_me_search_ctrl.sv - directed/randomized bench for me_search_ctrl with a raster-scan reference model
module tb_me_search_ctrl;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [15:0]       best_sad;
  logic signed [5:0] best_mvx;
  logic signed [5:0] best_mvy;

  me_search_ctrl_if #(.SAD_WIDTH(16), .MV_WIDTH(6)) bus ();

  me_search_ctrl #(
    .SAD_WIDTH(16), .SEARCH_RANGE(4), .MV_WIDTH(6), .ZERO_BIAS(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus),
    .busy(busy), .done(done), .best_sad(best_sad), .best_mvx(best_mvx), .best_mvy(best_mvy)
  );

  typedef struct {
    int x;
    int y;
    int due;
  } ent_t;

  int   sad_tab[9][9];
  ent_t q[$];
  int   cyc = 0;
  int   hs_count = 0, res_count = 0, done_count = 0;
  int   order_err = 0, stall_err = 0, seq_idx = 0;
  int   done_cyc = 0, last_res_cyc = 0;
  bit   rdy_rand = 0, spur_en = 0, flush = 0;
  int   lat_min = 1, lat_max = 1;
  int   n_pass = 0, n_total = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int tab_val(input int x, input int y);
    if (x < -4 || x > 4 || y < -4 || y > 4) return 0;
    return sad_tab[y+4][x+4];
  endfunction

  // behavioural datapath: random ready, in-order results with per-candidate latency, plus monitors
  initial begin
    int   mx, my, lat, due, last_due;
    bit   prev_stall;
    int   prev_x, prev_y;
    ent_t e;
    bus.cand_ready = 1'b0;
    bus.sad_valid  = 1'b0;
    bus.sad_in     = '0;
    prev_stall = 0; prev_x = 0; prev_y = 0; last_due = 0;
    forever begin
      @(negedge clk);
      mx = int'(bus.cand_mvx);
      my = int'(bus.cand_mvy);
      if (prev_stall && bus.cand_valid && (mx != prev_x || my != prev_y)) stall_err++;
      if (!busy) seq_idx = 0;
      bus.cand_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (flush || rst) q.delete();
      if (bus.cand_valid && bus.cand_ready) begin
        if (mx != (seq_idx % 9) - 4 || my != (seq_idx / 9) - 4) order_err++;
        seq_idx++;
        hs_count++;
        lat = $urandom_range(lat_min, lat_max);
        due = cyc + lat;
        if (due < last_due) due = last_due;
        last_due = due;
        e.x = mx; e.y = my; e.due = due;
        q.push_back(e);
      end
      prev_stall = bus.cand_valid && !bus.cand_ready;
      prev_x = mx;
      prev_y = my;
      if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        bus.sad_valid = 1'b1;
        bus.sad_in    = 16'(tab_val(e.x, e.y));
        res_count++;
        last_res_cyc = cyc;
      end else if (spur_en && !busy && !done && !bus.cand_valid && q.size() == 0) begin
        bus.sad_valid = 1'($urandom_range(0, 1));
        bus.sad_in    = '0;
      end else begin
        bus.sad_valid = 1'b0;
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(expv));
  endtask

  // reference: scan the window in raster order and keep the first strict minimum of the effective SAD
  task automatic ref_best(output int eb, output int ex, output int ey);
    eb = 65535; ex = 0; ey = 0;
    for (int y = -4; y <= 4; y++) begin
      for (int x = -4; x <= 4; x++) begin
        int e;
        e = sad_tab[y+4][x+4];
`ifdef ME_ZERO_BIAS_EN
        if (x == 0 && y == 0) e = (e > 4) ? e - 4 : 0;
`endif
        if (e < eb) begin
          eb = e; ex = x; ey = y;
        end
      end
    end
  endtask

  task automatic fill(input int lo, input int hi);
    for (int y = 0; y < 9; y++)
      for (int x = 0; x < 9; x++)
        sad_tab[y][x] = $urandom_range(lo, hi);
  endtask

  task automatic run_search(input bit mid_start, input string tag);
    int eb, ex, ey, h0, r0, d0, o0, s0, n;
    ref_best(eb, ex, ey);
    h0 = hs_count; r0 = res_count; d0 = done_count; o0 = order_err; s0 = stall_err;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (mid_start) begin
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    n = 0;
    while (done_count == d0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_handshakes"}, hs_count - h0, 81);
    check({tag, "_results"}, res_count - r0, 81);
    check({tag, "_done_pulses"}, done_count - d0, 1);
    check({tag, "_done_timing"}, done_cyc, last_res_cyc + 1);
    check({tag, "_raster_order"}, order_err - o0, 0);
    check({tag, "_stall_stable"}, stall_err - s0, 0);
    check({tag, "_best_sad"}, 32'(best_sad), eb);
    check({tag, "_best_mvx"}, 32'(best_mvx), ex);
    check({tag, "_best_mvy"}, 32'(best_mvy), ey);
    check({tag, "_busy_after"}, 32'(busy), 0);
  endtask

  initial begin
    int h0, d0, n;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cand_valid", 32'(bus.cand_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cand_mvx", 32'(bus.cand_mvx), 0);
    check("rst_cand_mvy", 32'(bus.cand_mvy), 0);
    check("rst_best_sad", 32'(best_sad), 0);
    check("rst_best_mvx", 32'(best_mvx), 0);
    check("rst_best_mvy", 32'(best_mvy), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single minimum at (2,-3), ready always high, one-cycle latency
    fill(100, 100);
    sad_tab[-3+4][2+4] = 7;
    run_search(0, "single_min");

    // all equal: earliest raster candidate wins
    fill(50, 50);
    run_search(0, "all_equal");

    // random ready, 0..5 cycle latency, minimum in the last corner
    rdy_rand = 1; lat_min = 0; lat_max = 5;
    fill(4, 1000);
    sad_tab[8][8] = 3;
    run_search(0, "stall_lat");
    repeat (5) @(negedge clk);
    check("hold_best_sad", 32'(best_sad), 3);
    check("hold_best_mvx", 32'(best_mvx), 4);
    check("hold_best_mvy", 32'(best_mvy), 4);

    // abort after 20 issues
    rdy_rand = 0; lat_min = 1; lat_max = 1;
    h0 = hs_count; d0 = done_count; n = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while ((hs_count - h0) < 20 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("abort_busy_before", 32'(busy), 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_cand_valid", 32'(bus.cand_valid), 0);
    flush = 1'b1;
    repeat (5) @(negedge clk);
    flush = 1'b0;
    check("abort_no_done", done_count - d0, 0);

    // asynchronous reset while draining
    lat_min = 5; lat_max = 5;
    fill(100, 200);
    h0 = hs_count; d0 = done_count; n = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while ((hs_count - h0) < 81 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_busy", 32'(busy), 1);
    check("drain_cand_valid", 32'(bus.cand_valid), 0);
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_best_sad", 32'(best_sad), 0);
    check("arst_best_mvx", 32'(best_mvx), 0);
    check("arst_best_mvy", 32'(best_mvy), 0);
    flush = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_no_done", done_count - d0, 0);

    // zero-vector bias case, also the run that follows the reset
    lat_min = 1; lat_max = 3;
    fill(200, 200);
    sad_tab[4][4] = 10;
    sad_tab[4][5] = 8;
    run_search(0, "bias");
`ifdef ME_ZERO_BIAS_EN
    check("bias_const_sad", 32'(best_sad), 6);
    check("bias_const_mvx", 32'(best_mvx), 0);
`else
    check("bias_const_sad", 32'(best_sad), 8);
    check("bias_const_mvx", 32'(best_mvx), 1);
`endif

    // spurious results while idle and a start pulse during ISSUE, with ties in the table
    spur_en = 1; rdy_rand = 1; lat_min = 0; lat_max = 4;
    fill(20, 60);
    repeat (10) @(negedge clk);
    run_search(1, "spurious");
    spur_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
